clk_div_sched: RTL and testbench

//   Run-time controller for a 50%-duty integer clock divider on the clk_in domain.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_sched_if.sv | 37 +++
 rtl/clk_div_core.sv | 63 ++++++
 rtl/clk_div_sched.sv | 125 ++++++++++++
 tb/tb_clk_div_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
//   Shared types and helpers for the run-time clock divider controller.
//   - state_t    : controller FSM states
//   - *_DFLT     : default parameter values used by the interface and the top
//   - half_count : (n+1)/2 with one extra bit, so n = all-ones cannot overflow
// ----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND,
      STOP
   } state_t;

   localparam int unsigned W_DFLT       = 8;
   localparam int unsigned DEF_DIV_DFLT = 7;
   localparam int unsigned MIN_DIV_DFLT = 2;

   // Number of source cycles the posedge duty register stays high for divisor n.
   // Divisors up to 32 bits are supported; the result carries one extra bit.
   function automatic logic [32:0] half_count(input logic [31:0] n);
      return ({1'b0, n} + 33'd1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// ----------------------------------------------------------------------------
// clk_div_sched_if
//   Control/status bundle between the config logic (master) and the divider
//   controller (slave).
//   en       master->slave  run request (level)
//   div_req  master->slave  divisor-change request (level, held until div_ack)
//   div_val  master->slave  requested divisor
//   div_ack  slave->master  one-cycle completion pulse
//   div_err  slave->master  one-cycle reject pulse, coincident with div_ack
//   busy     slave->master  accepted change waiting for a period boundary
//   cur_div  slave->master  divisor in effect
//   clk_out  slave->master  divided clock
// ----------------------------------------------------------------------------
interface clk_div_sched_if
   import clk_div_pkg::*;
#(
   parameter int unsigned W = W_DFLT
);
   logic         en;
   logic         div_req;
   logic [W-1:0] div_val;
   logic         div_ack;
   logic         div_err;
   logic         busy;
   logic [W-1:0] cur_div;
   logic         clk_out;

   modport master (
      output en, div_req, div_val,
      input  div_ack, div_err, busy, cur_div, clk_out
   );

   modport slave (
      input  en, div_req, div_val,
      output div_ack, div_err, busy, cur_div, clk_out
   );
endinterface

// File: rtl/clk_div_core.sv
// ----------------------------------------------------------------------------
// clk_div_core
//   50%-duty integer divider datapath.
//   clk_in   in   source clock
//   reset    in   asynchronous, active-high
//   run      in   1 = count, 0 = hold counter at 0 and force output low
//   div      in   divisor N (>= 2)
//   clk_out  out  divided clock
//   last     out  period boundary flag (cnt == N-1 while running)
//
//   p is registered from the current count, so it lags cnt by one cycle. n is
//   p re-timed on the falling edge; ANDing the two for odd N trims the high
//   phase by half a source cycle, giving exactly N/2 cycles high.
// ----------------------------------------------------------------------------
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int unsigned W = W_DFLT
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         run,
   input  logic [W-1:0] div,
   output logic         clk_out,
   output logic         last
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         p_q, p_d;
   logic         n_q;

   assign last = run && (cnt_q == div - W'(1));

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (!run || last) begin
         cnt_d = '0;
      end
      p_d = run && (33'(cnt_q) < half_count(32'(div)));
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         p_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         p_q   <= p_d;
      end
   end

   always_ff @(negedge clk_in or posedge reset) begin
      if (reset) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q;
      end
   end

   // Divisor only changes at a boundary, where p and n are both low.
   assign clk_out = div[0] ? (p_q & n_q) : p_q;

endmodule

// File: rtl/clk_div_sched.sv
// ----------------------------------------------------------------------------
// clk_div_sched
//   Run-time controller for a glitch-free 50%-duty clock divider.
//   clk_in  in     source clock
//   reset   in     asynchronous, active-high
//   bus     slave  en / div_req / div_val in; div_ack / div_err / busy /
//                  cur_div / clk_out out (see clk_div_sched_if)
//
//   Start/stop and divisor changes take effect only on period boundaries.
//   Requests are sampled only while no ack is pulsing and nothing is pending.
//   Illegal divisors (< MIN_DIV) are acked with div_err the next cycle.
// ----------------------------------------------------------------------------
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int unsigned W       = W_DFLT,
   parameter int unsigned DEF_DIV = DEF_DIV_DFLT,
   parameter int unsigned MIN_DIV = MIN_DIV_DFLT
) (
   input logic              clk_in,
   input logic              reset,
   clk_div_sched_if.slave   bus
);

   state_t       state_q, state_d;
   logic [W-1:0] cur_div_q, cur_div_d;
   logic [W-1:0] pend_div_q, pend_div_d;
   logic         ack_q, ack_d;
   logic         err_q, err_d;
   logic         run;
   logic         last;
   logic         sample;
   logic         legal;

   assign run    = (state_q != IDLE);
   assign sample = bus.div_req && !ack_q && (state_q != PEND);
   assign legal  = (bus.div_val >= W'(MIN_DIV));

   always_comb begin
      state_d    = state_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;

      if (sample && !legal) begin
         ack_d = 1'b1;
         err_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            // Applied immediately, so a coincident en=1 starts on the new divisor.
            if (sample && legal) begin
               cur_div_d = bus.div_val;
               ack_d     = 1'b1;
            end
            if (bus.en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (sample && legal) begin
               pend_div_d = bus.div_val;
               state_d    = PEND;
            end else if (!bus.en) begin
               // Dropping en on the boundary cycle ends the run right there.
               state_d = last ? IDLE : STOP;
            end
         end
         PEND: begin
            if (last) begin
               cur_div_d = pend_div_q;
               ack_d     = 1'b1;
               // The period just ended, so a dropped en means stop now.
               state_d   = bus.en ? RUN : IDLE;
            end
         end
         STOP: begin
            if (sample && legal) begin
               pend_div_d = bus.div_val;
               state_d    = PEND;
            end else if (bus.en) begin
               state_d = RUN;
            end else if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_div_q  <= W'(DEF_DIV);
         pend_div_q <= W'(DEF_DIV);
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_div_q  <= cur_div_d;
         pend_div_q <= pend_div_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign bus.div_ack = ack_q;
   assign bus.div_err = err_q;
   assign bus.busy    = (state_q == PEND);
   assign bus.cur_div = cur_div_q;

   clk_div_core #(
      .W (W)
   ) u_core (
      .clk_in  (clk_in),
      .reset   (reset),
      .run     (run),
      .div     (cur_div_q),
      .clk_out (bus.clk_out),
      .last    (last)
   );

endmodule

// File: tb/tb_clk_div_sched.sv
// ----------------------------------------------------------------------------
// tb_clk_div_sched
//   Directed bench for clk_div_sched (W=8, DEF_DIV=7, MIN_DIV=2).
//   Stimulus pushes the expected {div_err, cur_div} for every request into a
//   scoreboard queue; a monitor pops and compares on each div_ack pulse.
//   clk_out is measured in half source cycles by sampling 2 time units after
//   every clk_in edge.
// ----------------------------------------------------------------------------
module tb_clk_div_sched;

   logic clk_in = 1'b0;
   logic reset;

   always #5 clk_in = ~clk_in;

   clk_div_sched_if #(.W(8)) bus ();

   clk_div_sched #(
      .W       (8),
      .DEF_DIV (7),
      .MIN_DIV (2)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   typedef struct packed {
      logic       err;
      logic [7:0] div;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic void chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endfunction

   // Scoreboard monitor
   initial begin
      forever begin
         @(posedge clk_in);
         #2;
         if (bus.div_err === 1'b1 && bus.div_ack !== 1'b1) begin
            chk("err_without_ack", 1, 0);
         end
         if (bus.div_ack === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("ack_err", int'(bus.div_err), int'(e.err));
               chk("ack_cur_div", int'(bus.cur_div), int'(e.div));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   // Half-cycles until clk_out rises (-1 if it never does).
   task automatic wait_rise(output int h);
      logic prev;
      prev = bus.clk_out;
      h    = 0;
      for (int i = 0; i < 2000; i++) begin
         #5;
         h++;
         if (!prev && bus.clk_out) return;
         prev = bus.clk_out;
      end
      h = -1;
   endtask

   // Called right after a rise: high and low durations of one period, in halves.
   task automatic run_check(input string tag, input int exp_hi, input int exp_lo);
      int hi;
      int lo;
      hi = 1;
      for (int i = 0; i < 2000; i++) begin
         #5;
         if (bus.clk_out) hi++;
         else break;
      end
      lo = 1;
      for (int i = 0; i < 2000; i++) begin
         #5;
         if (!bus.clk_out) lo++;
         else break;
      end
      chk({tag, "_high"}, hi, exp_hi);
      chk({tag, "_low"}, lo, exp_lo);
   endtask

   task automatic do_req(input string tag, input int v, input int exp_err, input int exp_div,
                         input int exp_lat, input int exp_busy);
      int   lat;
      exp_t e;
      e.err = exp_err[0];
      e.div = exp_div[7:0];
      sb.push_back(e);
      bus.div_val = v[7:0];
      bus.div_req = 1'b1;
      tick();
      lat = 1;
      chk({tag, "_busy_next"}, int'(bus.busy), exp_busy);
      while (!bus.div_ack && lat < 600) begin
         tick();
         lat++;
      end
      chk({tag, "_ack_seen"}, int'(bus.div_ack), 1);
      if (exp_lat > 0) chk({tag, "_ack_latency"}, lat, exp_lat);
      chk({tag, "_busy_at_ack"}, int'(bus.busy), 0);
      bus.div_req = 1'b0;
   endtask

   initial begin
      int h;
      int hi;
      reset       = 1'b1;
      bus.en      = 1'b0;
      bus.div_req = 1'b0;
      bus.div_val = 8'd0;
      #3;
      chk("rst_clk_out", int'(bus.clk_out), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_ack", int'(bus.div_ack), 0);
      chk("rst_err", int'(bus.div_err), 0);
      chk("rst_cur_div", int'(bus.cur_div), 7);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Start at the default divisor: rise 1.5 cycles after en is sampled
      bus.en = 1'b1;
      wait_rise(h);
      chk("t1_first_rise", h, 5);
      run_check("t1_p1", 7, 7);
      run_check("t1_p2", 7, 7);

      // Rejected divisor
      tick();
      do_req("t3_rej", 1, 1, 7, 1, 0);
      wait_rise(h);
      run_check("t3_after_rej", 7, 7);

      // Change 7 -> 4 while running
      tick();
      do_req("t2", 4, 0, 4, -1, 1);
      wait_rise(h);
      chk("t2_rise_after_ack", h, 2);
      run_check("t2_p1", 4, 4);
      run_check("t2_p2", 4, 4);

      tick();
      do_req("to7", 7, 0, 7, -1, 1);
      wait_rise(h);
      run_check("to7", 7, 7);

      // Stop at cnt=2: finish the period, then stay low
      tick();
      bus.en = 1'b0;
      h = 0;
      for (int i = 0; i < 40; i++) begin
         #5;
         h++;
         if (!bus.clk_out) break;
      end
      chk("t4_fall", h, 6);
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         #5;
         if (bus.clk_out) hi++;
      end
      chk("t4_stays_low", hi, 0);
      tick();
      bus.en = 1'b1;
      wait_rise(h);
      chk("t4_restart_rise", h, 5);
      run_check("t4_restart", 7, 7);

      // Stop at cnt=2, re-enable at cnt=5: no gap
      tick();
      bus.en = 1'b0;
      tick();
      tick();
      tick();
      bus.en = 1'b1;
      wait_rise(h);
      chk("t4_no_gap", h, 7);
      run_check("t4_resume", 7, 7);

      // Change to 255 from IDLE, then start
      tick();
      bus.en = 1'b0;
      repeat (20) tick();
      chk("t5_idle_low", int'(bus.clk_out), 0);
      do_req("t5", 255, 0, 255, 1, 0);
      bus.en = 1'b1;
      wait_rise(h);
      chk("t5_first_rise", h, 5);
      run_check("t5_n255", 255, 255);

      // Request and en together in IDLE: first period already uses 4
      tick();
      bus.en = 1'b0;
      repeat (300) tick();
      chk("simul_idle_low", int'(bus.clk_out), 0);
      bus.en = 1'b1;
      do_req("simul", 4, 0, 4, 1, 0);
      wait_rise(h);
      chk("simul_first_rise", h, 2);
      run_check("simul_n4", 4, 4);

      // Odd divisor 9, then reset mid-high with a change pending
      tick();
      do_req("t6_to9", 9, 0, 9, -1, 1);
      wait_rise(h);
      run_check("t6_n9", 9, 9);
      tick();
      bus.div_val = 8'd12;
      bus.div_req = 1'b1;
      tick();
      chk("t6_pend_busy", int'(bus.busy), 1);
      chk("t6_pend_high", int'(bus.clk_out), 1);
      #1;
      reset       = 1'b1;
      bus.div_req = 1'b0;
      bus.en      = 1'b0;
      #1;
      chk("t6_rst_clk_out", int'(bus.clk_out), 0);
      chk("t6_rst_busy", int'(bus.busy), 0);
      chk("t6_rst_cur_div", int'(bus.cur_div), 7);
      chk("t6_rst_ack", int'(bus.div_ack), 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (30) tick();
      chk("t6_post_clk_out", int'(bus.clk_out), 0);
      chk("t6_post_cur_div", int'(bus.cur_div), 7);
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
